// File: rtl/pla_sel_sched.sv
// Round-robin scheduler driving one-hot bank/line selects for a PLA-style decoder.
// Define PLA_SEL_SCHED_PRIO0_EN to give requester 0 absolute priority in arbitration.
module pla_sel_sched #(
    parameter int NREQ = 4,
    parameter int HOLD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_bank,
    input  logic [4*NREQ-1:0] req_line,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [15:0]       sel_bank,
    output logic [15:0]       sel_line,
    output logic              sel_valid,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    bank_q, bank_d;
    logic [3:0]    line_q, line_d;

    logic [PW-1:0] arb_win;
    logic [3:0]    arb_bank;
    logic [3:0]    arb_line;

    // Search upward from ptr+1 so the last winner is considered last.
    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        arb_win = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[PW'(idx)]) begin
                found   = 1'b1;
                arb_win = PW'(idx);
            end
        end
`ifdef PLA_SEL_SCHED_PRIO0_EN
        if (req[0]) begin
            arb_win = '0;
        end
`endif
        arb_bank = '0;
        arb_line = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_win == PW'(i)) begin
                arb_bank = req_bank[4*i +: 4];
                arb_line = req_line[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            bank_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    win_d   = arb_win;
                    bank_d  = arb_bank;
                    line_d  = arb_line;
                    cnt_d   = 4'(HOLD - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // Counter only advances on enabled cycles; a stall just pauses it.
                if (en) begin
                    if (cnt_q == '0) begin
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            GAP: begin
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = '0;
        ack       = '0;
        sel_bank  = '0;
        sel_line  = '0;
        sel_valid = 1'b0;
        busy      = (state_q != IDLE);
        if (state_q == DRIVE) begin
            gnt = GNT_ONE << win_q;
            if (en) begin
                sel_valid = 1'b1;
                sel_bank  = 16'h0001 << bank_q;
                sel_line  = 16'h0001 << line_q;
                if (cnt_q == '0) begin
                    ack = GNT_ONE << win_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_pla_sel_sched.sv
// Directed bench for pla_sel_sched: per-cycle vector table plus rotation and reset sequences.
module tb_pla_sel_sched;

    localparam int NREQ = 4;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_bank = '0;
    logic [15:0] req_line = '0;
    logic [3:0]  gnt, ack;
    logic [15:0] sel_bank, sel_line;
    logic        sel_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;

    pla_sel_sched #(.NREQ(NREQ), .HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .req_bank(req_bank), .req_line(req_line),
        .gnt(gnt), .ack(ack), .sel_bank(sel_bank), .sel_line(sel_line),
        .sel_valid(sel_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [15:0] bank;
        logic [15:0] line;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [15:0] sb;
        logic [15:0] sl;
        logic        sv;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic [3:0] r, input logic [15:0] b, input logic [15:0] l,
                       input logic [3:0] g, input logic [3:0] a, input logic [15:0] sb,
                       input logic [15:0] sl, input logic sv, input logic bz);
        vec_t v;
        v.en = e; v.req = r; v.bank = b; v.line = l;
        v.gnt = g; v.ack = a; v.sb = sb; v.sl = sl; v.sv = sv; v.busy = bz;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [41:0] outs();
        return {gnt, ack, sel_bank, sel_line, sel_valid, busy};
    endfunction

    initial begin
        int order[$];
        int hcnt, acnt, done, w, cyc, ack_seen;
        logic [3:0] prev;
        logic seen;

        //  en  req      bank      line      gnt      ack      sel_bank  sel_line  sv bz
        // single grant to requester 0, req dropped once driving
        add(1, 4'b0001, 16'h0005, 16'h0009, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        add(1, 4'b0001, 16'h0005, 16'h0009, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(1, 4'b0000, 16'h0005, 16'h0009, 4'b0001, 4'b0000, 16'h0020, 16'h0200, 1, 1);
        add(1, 4'b0000, 16'h0005, 16'h0009, 4'b0001, 4'b0000, 16'h0020, 16'h0200, 1, 1);
        add(1, 4'b0000, 16'h0005, 16'h0009, 4'b0001, 4'b0001, 16'h0020, 16'h0200, 1, 1);
        add(1, 4'b0000, 16'h0005, 16'h0009, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        // en low in IDLE and in ARB
        add(0, 4'b0010, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        add(1, 4'b0010, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        add(0, 4'b0010, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(0, 4'b0010, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        add(1, 4'b0010, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        add(1, 4'b0010, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        // grant to 1 with a 2-cycle en stall mid-DRIVE
        add(1, 4'b0000, 16'h0030, 16'h00F0, 4'b0010, 4'b0000, 16'h0008, 16'h8000, 1, 1);
        add(0, 4'b0000, 16'h0030, 16'h00F0, 4'b0010, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(0, 4'b0000, 16'h0030, 16'h00F0, 4'b0010, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(1, 4'b0000, 16'h0030, 16'h00F0, 4'b0010, 4'b0000, 16'h0008, 16'h8000, 1, 1);
        add(1, 4'b0000, 16'h0030, 16'h00F0, 4'b0010, 4'b0010, 16'h0008, 16'h8000, 1, 1);
        add(1, 4'b0000, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(1, 4'b0000, 16'h0030, 16'h00F0, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        // grant to 2; codes scrambled and req dropped while driving
        add(1, 4'b0100, 16'h0700, 16'h0200, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);
        add(1, 4'b0100, 16'h0700, 16'h0200, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(1, 4'b0000, 16'h0F00, 16'h0100, 4'b0100, 4'b0000, 16'h0080, 16'h0004, 1, 1);
        add(1, 4'b0000, 16'hFFFF, 16'hAAAA, 4'b0100, 4'b0000, 16'h0080, 16'h0004, 1, 1);
        add(1, 4'b0000, 16'h1234, 16'h5678, 4'b0100, 4'b0100, 16'h0080, 16'h0004, 1, 1);
        add(1, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 1);
        add(1, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk("reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            en = vq[i].en; req = vq[i].req; req_bank = vq[i].bank; req_line = vq[i].line;
            #2;
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vq[i].gnt, vq[i].ack, vq[i].sb, vq[i].sl, vq[i].sv, vq[i].busy}));
            @(posedge clk);
            #1;
        end

        // rotation with all requesters active, starting from reset pointer
        rst_n = 1'b0;
        en = 1'b1; req = 4'b1111; req_bank = 16'h4321; req_line = 16'hCDEF;
        @(negedge clk);
        rst_n = 1'b1;
        prev = '0; done = 0; hcnt = 0; acnt = 0; w = 0;
        for (int c = 0; c < 100 && done < 5; c++) begin
            @(posedge clk);
            #2;
            if (gnt != '0) begin
                if (prev == '0) begin
                    w = oh_idx(gnt);
                    order.push_back(w);
                    hcnt = 0; acnt = 0;
                    chk("rot_sel_bank", 64'(sel_bank), 64'(16'h0001 << (w + 1)));
                end
                hcnt++;
                if (ack != '0) begin
                    acnt++;
                    chk("rot_ack_target", 64'(ack), 64'(gnt));
                end
            end else if (prev != '0) begin
                chk("rot_hold_len", 64'(hcnt), 64'(HOLD));
                chk("rot_ack_count", 64'(acnt), 64'd1);
                done++;
            end
            prev = gnt;
        end
        chk("rot_grants_done", 64'(done), 64'd5);
        for (int k = 0; k < 5; k++) begin
            int act, exp;
            act = (k < order.size()) ? order[k] : -1;
`ifdef PLA_SEL_SCHED_PRIO0_EN
            exp = 0;
`else
            exp = k % NREQ;
`endif
            chk($sformatf("rot_order%0d", k), 64'(act), 64'(exp));
        end

        // async reset in the middle of a grant
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #2;
            if (gnt != '0) seen = 1'b1;
        end
        chk("rst_wait_drive", 64'(seen), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_outs", 64'(outs()), 64'd0);
        @(posedge clk);
        #2 chk("rst_held_outs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0; cyc = 0; ack_seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #2;
            cyc++;
            if (ack != '0) ack_seen++;
            if (gnt != '0) seen = 1'b1;
        end
        chk("rst_no_ack", 64'(ack_seen), 64'd0);
        chk("rst_regrant_latency", 64'(cyc), 64'd2);
        chk("rst_regrant_gnt", 64'(gnt), 64'(4'b0001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pla_sel_sched.md
PLA_SEL_SCHED -- requirements
Module: pla_sel_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter HOLD, default 3, select-drive cycles per grant (1..15).
REQ-003 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  decode enable (x04|x05 equivalent); low stalls the scheduler.
- req  in  NREQ  per-requester level request.
- req_bank  in  4*NREQ  bank code per requester (requester i at bits 4i+3:4i).
- req_line  in  4*NREQ  line code per requester, same packing.
- gnt  out  NREQ  one-hot grant, held for the whole grant.
- ack  out  NREQ  one-cycle pulse to the granted requester on its final DRIVE cycle.
- sel_bank  out  16  one-hot decode of the latched bank code.
- sel_line  out  16  one-hot decode of the latched line code.
- sel_valid  out  1  high while sel_bank/sel_line are driven.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 SHALL implement FSM IDLE, ARB, DRIVE, GAP.
REQ-005 IDLE -> ARB when en=1 and any req bit is set; otherwise stay in IDLE.
REQ-006 ARB SHALL pick the winner round-robin, searching upward from ptr+1 modulo NREQ.
REQ-007 ARB SHALL latch the winner's bank and line codes, set gnt, load hold counter with HOLD-1, and go to DRIVE; this takes 1 cycle.
REQ-008 DRIVE SHALL set sel_valid=1, sel_bank=1<<bank and sel_line=1<<line; each output has exactly one bit set.
REQ-009 DRIVE SHALL decrement the counter each cycle en=1; when the counter is 0 it SHALL pulse ack for the winner and go to GAP.
REQ-010 GAP SHALL last 1 cycle with sel_valid=0, bank/line selects zero and gnt cleared; it SHALL set ptr to the winner index and go to IDLE.
REQ-011 en=0 in DRIVE SHALL freeze the counter, force sel_bank, sel_line and sel_valid to 0, and hold gnt; the counter resumes from the same value when en returns to 1.
REQ-012 en=0 in ARB SHALL return the FSM to IDLE with no grant made.
REQ-013 Dropping req or changing the codes after ARB SHALL NOT affect the grant in progress, because the codes are latched.
REQ-014 Latency from req rise in IDLE to first sel_valid SHALL be 2 cycles; a grant occupies HOLD+1 cycles plus 1 ARB cycle.
REQ-015 Requests raised while busy SHALL be evaluated at the next ARB; no request is lost while held.
REQ-016 Arbitration SHALL be starvation-free: with all req high, grants rotate 0,1,...,NREQ-1,0.

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, ptr=NREQ-1, counter=0, gnt=0, ack=0, sel_bank=0, sel_line=0, sel_valid=0, busy=0.
REQ-018 Reset asserted mid-DRIVE SHALL abort the grant with no ack; the first grant after release SHALL follow REQ-006 from ptr=NREQ-1.

Configuration
REQ-019 Macro PLA_SEL_SCHED_PRIO0_EN: when defined, requester 0 SHALL win any ARB in which req[0]=1, with round-robin among the others otherwise; when undefined, pure round-robin per REQ-006 SHALL apply.

Verification
REQ-020 Reset then req=0001, bank=5, line=9, en=1 -> gnt=0001 at cycle 2; sel_bank=0x0020 and sel_line=0x0200 for 3 cycles; ack[0] on the 3rd; busy low after GAP.
REQ-021 req=1111 held -> grant order 0,1,2,3,0 (0,0,0... with PRIO0_EN); each grant spans 5 cycles.
REQ-022 en dropped for 2 cycles mid-DRIVE -> selects and sel_valid are 0 during the drop; total DRIVE cycles with en=1 remain 3; ack appears 2 cycles later.
REQ-023 rst_n pulsed low mid-DRIVE -> all outputs 0 asynchronously, no ack; next grant with req=1111 goes to requester 0.
REQ-024 Codes changed and req dropped during DRIVE -> sel outputs keep the latched values, ack still issued.
